// File: rtl/demod_pkg.sv
// Shared types and default constants for the 16QAM demodulator phase logic.
package demod_pkg;

    // Phase controller states; encoding 3 is unused and recovers to ACQ.
    typedef enum logic [1:0] {
        ACQ  = 2'd0,
        HOLD = 2'd1,
        LOCK = 2'd2
    } demod_pc_state_t;

    localparam int DEMOD_WIN       = 32;
    localparam int DEMOD_THRESH_HI = 22;
    localparam int DEMOD_THRESH_LO = 8;

endpackage

// File: rtl/demod_sat_cnt.sv
// Up-counter with enable, synchronous clear and saturation at MAX.
module demod_sat_cnt #(
    parameter int          W   = 8,
    parameter int unsigned MAX = 255
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] cnt
);

    localparam logic [W-1:0] MAX_V = W'(MAX);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    // Clear wins over increment; increments stop once MAX is reached.
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (inc && (cnt_q != MAX_V)) begin
            cnt_d = cnt_q + W'(1);
        end
    end

    // Count register with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt = cnt_q;

endmodule

// File: rtl/demod_phase_ctrl.sv
// Carrier-phase decision controller: flips the 90-degree correction when the
// shifted-symbol count is high, holds off after each flip and tracks lock.
module demod_phase_ctrl
    import demod_pkg::*;
#(
    parameter int WIN       = DEMOD_WIN,
    parameter int THRESH_HI = DEMOD_THRESH_HI,
    parameter int THRESH_LO = DEMOD_THRESH_LO,
    parameter int HOLDOFF   = 32,
    parameter int LOCK_CNT  = 64,
    parameter int MAX_SLIPS = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       en,
    input  logic [$clog2(WIN+1)-1:0]   count_num,
    output logic                       phase_shift,
    output logic                       locked,
    output logic                       flip_pulse,
    output logic [7:0]                 slip_cnt,
    output logic [1:0]                 state
);

    localparam int CW = $clog2(WIN + 1);
    localparam int HW = $clog2(HOLDOFF + 1);
    localparam int QW = $clog2(LOCK_CNT + 1);
    localparam int SW = $clog2(MAX_SLIPS + 1);

    localparam logic [CW-1:0] TH_HI      = CW'(THRESH_HI);
    localparam logic [CW-1:0] TH_LO      = CW'(THRESH_LO);
    localparam logic [HW-1:0] HOLD_INIT  = HW'(HOLDOFF - 1);
    localparam logic [QW-1:0] QUIET_LAST = QW'(LOCK_CNT - 1);
    localparam logic [SW-1:0] SLIP_LAST  = SW'(MAX_SLIPS - 1);

    demod_pc_state_t state_q, state_d;
    logic            phase_q, phase_d;
    logic            locked_q, locked_d;
    logic            flip_q, flip_d;
    logic [HW-1:0]   hold_q, hold_d;

    logic [QW-1:0]   quiet_cnt;
    logic [SW-1:0]   consec_slips;
    logic            slip_inc;
    logic            quiet_inc, quiet_clr;
    logic            consec_inc, consec_clr;

    logic            is_hi;
    logic            is_quiet;

    assign is_hi    = (count_num >= TH_HI);
    assign is_quiet = (count_num <= TH_LO);

    // Next-state and counter control; everything freezes while en is low.
    always_comb begin
        state_d    = state_q;
        phase_d    = phase_q;
        locked_d   = locked_q;
        flip_d     = 1'b0;
        hold_d     = hold_q;
        slip_inc   = 1'b0;
        quiet_inc  = 1'b0;
        quiet_clr  = 1'b0;
        consec_inc = 1'b0;
        consec_clr = 1'b0;
        case (state_q)
            ACQ: begin
                if (en) begin
                    if (is_hi) begin
                        phase_d   = ~phase_q;
                        flip_d    = 1'b1;
                        slip_inc  = 1'b1;
                        quiet_clr = 1'b1;
                        hold_d    = HOLD_INIT;
                        state_d   = HOLD;
                    end else if (is_quiet) begin
                        if (quiet_cnt == QUIET_LAST) begin
                            locked_d   = 1'b1;
                            consec_clr = 1'b1;
                            quiet_clr  = 1'b1;
                            state_d    = LOCK;
                        end else begin
                            quiet_inc = 1'b1;
                        end
                    end else begin
                        quiet_clr = 1'b1;
                    end
                end
            end
            HOLD: begin
                if (en) begin
                    if (hold_q == '0) begin
                        state_d = locked_q ? LOCK : ACQ;
                    end else begin
                        hold_d = hold_q - HW'(1);
                    end
                end
            end
            LOCK: begin
                if (en) begin
                    if (is_hi) begin
                        phase_d   = ~phase_q;
                        flip_d    = 1'b1;
                        slip_inc  = 1'b1;
                        quiet_clr = 1'b1;
                        hold_d    = HOLD_INIT;
                        state_d   = HOLD;
                        if (consec_slips == SLIP_LAST) begin
                            locked_d   = 1'b0;
                            consec_clr = 1'b1;
                        end else begin
                            consec_inc = 1'b1;
                        end
                    end else if (is_quiet) begin
                        if (quiet_cnt == QUIET_LAST) begin
                            consec_clr = 1'b1;
                            quiet_clr  = 1'b1;
                        end else begin
                            quiet_inc = 1'b1;
                        end
                    end else begin
                        quiet_clr = 1'b1;
                    end
                end
            end
            default: begin
                state_d  = ACQ;
                locked_d = 1'b0;
            end
        endcase
    end

    // State, phase, lock, pulse and holdoff registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ACQ;
            phase_q  <= 1'b0;
            locked_q <= 1'b0;
            flip_q   <= 1'b0;
            hold_q   <= '0;
        end else begin
            state_q  <= state_d;
            phase_q  <= phase_d;
            locked_q <= locked_d;
            flip_q   <= flip_d;
            hold_q   <= hold_d;
        end
    end

    demod_sat_cnt #(.W(8), .MAX(255)) u_slip_cnt (
        .clk (clk),
        .rst (rst),
        .clr (1'b0),
        .inc (slip_inc),
        .cnt (slip_cnt)
    );

    demod_sat_cnt #(.W(QW), .MAX(LOCK_CNT)) u_quiet_cnt (
        .clk (clk),
        .rst (rst),
        .clr (quiet_clr),
        .inc (quiet_inc),
        .cnt (quiet_cnt)
    );

    demod_sat_cnt #(.W(SW), .MAX(MAX_SLIPS)) u_consec_slips (
        .clk (clk),
        .rst (rst),
        .clr (consec_clr),
        .inc (consec_inc),
        .cnt (consec_slips)
    );

    assign phase_shift = phase_q;
    assign locked      = locked_q;
    assign flip_pulse  = flip_q;
    assign state       = state_q;

endmodule
